// File: rtl/apb_requester_if.sv
// Bundle of the command, response and APB3 signals around apb_requester.
// The master modport is the requester's view; the slave modport is the
// view of whatever sits around it (command source, response sink, completer).
interface apb_requester_if;
  // Command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  // Response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  // APB3 bus
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_requester.sv
// APB3 requester: turns one command at a time into an APB3 transfer and
// returns the completer's answer (or a timeout abort) as a response.
//
// Handshakes: a beat moves on a rising PCLK edge where valid and ready are
// both 1. A source keeps valid high and its payload stable until that edge;
// ready never depends combinationally on valid. cmd_ready is 1 only in
// IDLE; rsp_valid is 1 only in RESP, with the rsp_* fields held stable there.
module apb_requester #(
  parameter int TIMEOUT = 16
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_requester_if.master bus,
  output logic [1:0]      state_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Wait counter counts ACCESS edges seen with PREADY low.
  localparam int             CW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit             TIMEOUT_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0]  CNT_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0]  CNT_LAST   = TIMEOUT_EN ? CW'(TIMEOUT - 1) : '0;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pwrite_q, pwrite_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          to_q, to_d;

  // Next-state, bus capture and response capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    to_d     = to_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d  = S_SETUP;
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
      end
      S_ACCESS: begin
        if (bus.PREADY) begin
          // Completion wins over a timeout landing on the same edge.
          state_d = S_RESP;
          rdata_d = pwrite_q ? 32'h0 : bus.PRDATA;
          err_d   = bus.PSLVERR;
          to_d    = 1'b0;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          state_d = S_RESP;
          rdata_d = 32'h0;
          err_d   = 1'b1;
          to_d    = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any transfer in flight.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= 32'h0;
      pwdata_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end

  // Control outputs decode straight from the state register.
  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.PSEL        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign bus.PENABLE     = (state_q == S_ACCESS);
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = to_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester (TIMEOUT=4): directed commands, a scripted APB
// completer, and a response scoreboard fed from an expected queue.
module tb_apb_requester;

  logic       PCLK;
  logic       PRESET;
  logic [1:0] state_o;

  apb_requester_if bus ();

  apb_requester #(.TIMEOUT(4)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];   // {timeout, err, rdata}

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- completer model ----------------
  int   wait_n   = 0;     // ACCESS cycles with PREADY low before ready
  bit   stuck    = 0;     // never assert PREADY
  logic [31:0] rd_val  = 32'h0;
  logic        err_val = 1'b0;

  initial begin
    int acc_k;
    acc_k       = 0;
    bus.PREADY  = 1'b0;
    bus.PRDATA  = 32'h0;
    bus.PSLVERR = 1'b0;
    forever begin
      @(posedge PCLK); #1;
      if (bus.PSEL && bus.PENABLE) begin
        bus.PREADY  = !stuck && (acc_k >= wait_n);
        bus.PRDATA  = rd_val;
        bus.PSLVERR = err_val;
        acc_k++;
      end else begin
        // Garbage outside ACCESS must be ignored by the requester.
        acc_k       = 0;
        bus.PREADY  = 1'($urandom_range(0, 1));
        bus.PRDATA  = $urandom();
        bus.PSLVERR = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- bus tracker: stability and ACCESS length ----------------
  int          acc_cnt      = 0;
  int          last_acc_len = 0;
  logic [31:0] s_addr, s_wdata;
  logic        s_write;

  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (bus.PSEL && !bus.PENABLE) begin
        s_addr  = bus.PADDR;
        s_wdata = bus.PWDATA;
        s_write = bus.PWRITE;
        acc_cnt = 0;
      end else if (bus.PSEL && bus.PENABLE) begin
        acc_cnt++;
        chk("paddr_stable",  64'(bus.PADDR),  64'(s_addr));
        chk("pwdata_stable", 64'(bus.PWDATA), 64'(s_wdata));
        chk("pwrite_stable", 64'(bus.PWRITE), 64'(s_write));
      end
      if (!bus.PSEL && acc_cnt != 0) begin
        last_acc_len = acc_cnt;
        acc_cnt      = 0;
      end
    end else begin
      acc_cnt = 0;
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge PCLK) begin
    if (!PRESET && bus.rsp_valid) begin
      chk("resp_psel",      64'(bus.PSEL),      64'(0));
      chk("resp_penable",   64'(bus.PENABLE),   64'(0));
      chk("resp_cmd_ready", 64'(bus.cmd_ready), 64'(0));
      if (bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(1), 64'(0));
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          chk("rsp_fields", 64'({bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata}), 64'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [33:0] e);
    bit acc;
    exp_q.push_back(e);
    @(posedge PCLK); #1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge PCLK);
      if (bus.cmd_ready) acc = 1;
    end
    if (!acc) chk("cmd_accept_timeout", 64'(0), 64'(1));
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge PCLK);
      if (bus.cmd_ready) done = 1;
    end
    if (!done) chk("idle_timeout", 64'(0), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [33:0] held;
    bit          seen;
    PRESET        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_state",   64'(state_o),         64'(0));
    chk("rst_psel",    64'(bus.PSEL),        64'(0));
    chk("rst_penable", 64'(bus.PENABLE),     64'(0));
    chk("rst_pwrite",  64'(bus.PWRITE),      64'(0));
    chk("rst_paddr",   64'(bus.PADDR),       64'(0));
    chk("rst_pwdata",  64'(bus.PWDATA),      64'(0));
    chk("rst_rvalid",  64'(bus.rsp_valid),   64'(0));
    chk("rst_rdata",   64'(bus.rsp_rdata),   64'(0));
    chk("rst_rerr",    64'(bus.rsp_err),     64'(0));
    chk("rst_rto",     64'(bus.rsp_timeout), 64'(0));
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));

    // Write, zero wait states, minimum latency
    wait_n = 0; stuck = 0; rd_val = 32'h0; err_val = 1'b0;
    send_cmd(1'b1, 32'h0, 32'hA5A5A5A5, {1'b0, 1'b0, 32'h0});
    @(negedge PCLK);
    chk("lat_n1_psel",    64'(bus.PSEL),    64'(1));
    chk("lat_n1_penable", 64'(bus.PENABLE), 64'(0));
    chk("lat_n1_paddr",   64'(bus.PADDR),   64'(32'h0));
    chk("lat_n1_pwdata",  64'(bus.PWDATA),  64'(32'hA5A5A5A5));
    chk("lat_n1_pwrite",  64'(bus.PWRITE),  64'(1));
    @(negedge PCLK);
    chk("lat_n2_psel",    64'(bus.PSEL),    64'(1));
    chk("lat_n2_penable", 64'(bus.PENABLE), 64'(1));
    @(negedge PCLK);
    chk("lat_n3_rvalid",  64'(bus.rsp_valid), 64'(1));
    wait_idle();

    // Read with two wait states
    wait_n = 2; rd_val = 32'h12345678; err_val = 1'b0;
    send_cmd(1'b0, 32'h1, 32'hFFFF0000, {1'b0, 1'b0, 32'h12345678});
    wait_idle();
    chk("wait2_access_len", 64'(last_acc_len), 64'(3));

    // Read with slave error
    wait_n = 0; rd_val = 32'hDEADBEEF; err_val = 1'b1;
    send_cmd(1'b0, 32'h7, 32'h0, {1'b0, 1'b1, 32'hDEADBEEF});
    wait_idle();

    // Write with slave error: read data forced to zero
    rd_val = 32'h99999999; err_val = 1'b1;
    send_cmd(1'b1, 32'h8, 32'h13579BDF, {1'b0, 1'b1, 32'h0});
    wait_idle();

    // Timeout: PREADY never rises
    stuck = 1; rd_val = 32'hFEEDFACE; err_val = 1'b0;
    send_cmd(1'b0, 32'h20, 32'h0, {1'b1, 1'b1, 32'h0});
    wait_idle();
    chk("timeout_access_len", 64'(last_acc_len), 64'(4));

    // PREADY on the timeout edge completes normally
    stuck = 0; wait_n = 3; rd_val = 32'h0F0F0F0F; err_val = 1'b0;
    send_cmd(1'b0, 32'h24, 32'h0, {1'b0, 1'b0, 32'h0F0F0F0F});
    wait_idle();
    chk("edge_access_len", 64'(last_acc_len), 64'(4));

    // Response back-pressure for 5 cycles, second command waiting
    wait_n = 0; rd_val = 32'h0BADF00D; err_val = 1'b0;
    bus.rsp_ready = 1'b0;
    send_cmd(1'b0, 32'h40, 32'h0, {1'b0, 1'b0, 32'h0BADF00D});
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge PCLK);
      if (bus.rsp_valid) seen = 1;
    end
    if (!seen) chk("rsp_wait_timeout", 64'(0), 64'(1));
    held = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
    chk("bp_first_rsp", 64'(held), 64'({1'b0, 1'b0, 32'h0BADF00D}));
    @(posedge PCLK); #1;
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h44;
    bus.cmd_wdata = 32'h00001111;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk("bp_rvalid",  64'(bus.rsp_valid), 64'(1));
      chk("bp_stable",  64'({bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata}), 64'(held));
      chk("bp_cmd_rdy", 64'(bus.cmd_ready), 64'(0));
      chk("bp_psel",    64'(bus.PSEL),      64'(0));
    end
    @(posedge PCLK); #1;
    bus.rsp_ready = 1'b1;
    @(negedge PCLK);
    chk("bp_hs_cmd_rdy", 64'(bus.cmd_ready), 64'(0));
    @(negedge PCLK);
    chk("bp_after_hs_cmd_rdy", 64'(bus.cmd_ready), 64'(1));
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("bp_second_psel",    64'(bus.PSEL),    64'(1));
    chk("bp_second_penable", 64'(bus.PENABLE), 64'(0));
    chk("bp_second_paddr",   64'(bus.PADDR),   64'(32'h44));
    wait_idle();

    // Reset pulsed during ACCESS abandons the transfer
    stuck = 1;
    send_cmd(1'b0, 32'h30, 32'h0, {1'b0, 1'b0, 32'h0});
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge PCLK);
      if (bus.PENABLE) seen = 1;
    end
    if (!seen) chk("access_wait_timeout", 64'(0), 64'(1));
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    void'(exp_q.pop_back());
    @(negedge PCLK);
    chk("mid_rst_psel",      64'(bus.PSEL),      64'(0));
    chk("mid_rst_penable",   64'(bus.PENABLE),   64'(0));
    chk("mid_rst_rvalid",    64'(bus.rsp_valid), 64'(0));
    chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    stuck = 0; wait_n = 0; err_val = 1'b0;
    send_cmd(1'b1, 32'h80, 32'hCAFEF00D, {1'b0, 1'b0, 32'h0});
    @(negedge PCLK);
    chk("post_rst_pwdata", 64'(bus.PWDATA), 64'(32'hCAFEF00D));
    wait_idle();

    repeat (2) @(posedge PCLK);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
